coord_queue: RTL and testbench

COORD_QUEUE -- requirements
Module: coord_queue

---
 rtl/coord_queue_pkg.sv | 26 ++
 rtl/coord_queue_mem.sv | 36 +++
 rtl/coord_queue.sv | 106 ++++++++++
 tb/tb_coord_queue.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/coord_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coord_queue_pkg
// Description : Shared coordinate constants and types. Used by the queue and
//               the stack blocks so both keep entries in the same {x,y} form.
// Revision    : 1.0 - initial release
// ============================================================================
package coord_queue_pkg;

    // Width of one coordinate component
    localparam int COORD_W     = 4;
    // Default number of stored entries (power of two)
    localparam int COORD_DEPTH = 16;
    // One stored entry is {x,y}, x in the upper half
    localparam int ENTRY_W     = 2 * COORD_W;

    // Which of the two requests actually take effect on an edge
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_kind_t;

endpackage : coord_queue_pkg
`default_nettype wire

// File: rtl/coord_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : coord_queue_mem
// Description : Coordinate storage array. One synchronous write port and one
//               asynchronous read port. No reset: stale contents are never
//               reachable because the controller's count gates every read.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_queue_mem #(
    parameter int DEPTH = 16,
    parameter int EW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Write port: commit the entry on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so a pop sees the head entry within the
    // same cycle it is requested; a simultaneous write to the same slot only
    // lands at the edge, after the old value has been captured.
    assign rdata = mem[raddr];

endmodule : coord_queue_mem
`default_nettype wire

// File: rtl/coord_queue.sv
`default_nettype none
// ============================================================================
// Module      : coord_queue
// Description : FIFO of {x,y} coordinate pairs. Pointer/count control lives
//               here; storage is the coord_queue_mem sub-module. Dequeued
//               data is registered with a one-cycle valid pulse, refused
//               requests produce a one-cycle fail pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_queue
    import coord_queue_pkg::*;
#(
    parameter int DEPTH = COORD_DEPTH,   // must be a power of two, >= 2
    parameter int CW    = COORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CW-1:0]          xIn,
    input  logic [CW-1:0]          yIn,
    input  logic                   push,
    input  logic                   pop,
    output logic [CW-1:0]          xOut,
    output logic [CW-1:0]          yOut,
    output logic                   valid,
    output logic                   fail,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int EW   = 2 * CW;

    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CNTW-1:0] count_next;
    logic [EW-1:0]   rd_entry;
    logic            do_pop;
    logic            do_push;
    logic            req_fail;
    op_kind_t        op;

    // Status flags are a pure decode of the occupancy count
    assign empty = (count == '0);
    assign full  = (count == CNTW'(DEPTH));

    // A pop needs something stored. A push needs a free slot, except that a
    // pop on the same edge frees one, so a full queue still accepts a push
    // paired with a pop. With an empty queue the pop fails even though the
    // push proceeds: nothing falls through from input to output.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign req_fail = (pop && empty) || (push && !do_push);
    assign op       = op_kind_t'({do_push, do_pop});

    // Occupancy update from the accepted operations
    always_comb begin
        count_next = count;
        case (op)
            OP_PUSH: count_next = count + CNTW'(1);
            OP_POP:  count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count and the registered output pair; reset drops every
    // queued entry at once and masks any request presented while held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            xOut  <= '0;
            yOut  <= '0;
            valid <= 1'b0;
            fail  <= 1'b0;
        end else begin
            count <= count_next;
            valid <= do_pop;
            fail  <= req_fail;
            if (do_push) begin
                tail <= tail + AW'(1);   // wraps modulo DEPTH
            end
            if (do_pop) begin
                head <= head + AW'(1);   // wraps modulo DEPTH
                xOut <= rd_entry[EW-1:CW];
                yOut <= rd_entry[CW-1:0];
            end
        end
    end

    coord_queue_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (tail),
        .wdata ({xIn, yIn}),
        .raddr (head),
        .rdata (rd_entry)
    );

endmodule : coord_queue
`default_nettype wire

// File: tb/tb_coord_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_coord_queue
// Description : Self-checking bench for coord_queue. A queue of expected
//               {x,y} entries is filled as pushes are driven and drained as
//               the design reports pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coord_queue;

    localparam int DEPTH = 16;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] xIn, yIn;
    logic          push, pop;
    logic [CW-1:0] xOut, yOut;
    logic          valid, fail, empty, full;
    logic [4:0]    count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2*CW-1:0] sb[$];          // expected queue contents, oldest first
    logic [2*CW-1:0] exp_out = '0;   // expected {xOut,yOut}

    coord_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .xIn   (xIn),
        .yIn   (yIn),
        .push  (push),
        .pop   (pop),
        .xOut  (xOut),
        .yOut  (yOut),
        .valid (valid),
        .fail  (fail),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the scoreboard state
    task automatic check_all(input string tag, input logic exp_valid, input logic exp_fail);
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
        check({tag, ".fail"},  32'(fail),  32'(exp_fail));
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
        check({tag, ".out"},   32'({xOut, yOut}), 32'(exp_out));
    endtask

    // One clock of stimulus: predict the outcome, then compare after the edge
    task automatic step(input string tag, input logic p, input logic q,
                        input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic pop_ok, push_ok, exp_fail;
        @(negedge clk);
        push = p; pop = q; xIn = x; yIn = y;
        pop_ok   = q && (sb.size() > 0);
        push_ok  = p && ((sb.size() < DEPTH) || pop_ok);
        exp_fail = (q && !pop_ok) || (p && !push_ok);
        if (pop_ok)  exp_out = sb.pop_front();
        if (push_ok) sb.push_back({x, y});
        @(posedge clk);
        #1;
        check_all(tag, pop_ok, exp_fail);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; xIn = '0; yIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Pop on an empty queue is refused
        step("pop_empty", 1'b0, 1'b1, 4'd0, 4'd0);
        step("idle0",     1'b0, 1'b0, 4'd0, 4'd0);

        // Three pushes then three pops in order
        step("push35",  1'b1, 1'b0, 4'd3,  4'd5);
        step("push72",  1'b1, 1'b0, 4'd7,  4'd2);
        step("push150", 1'b1, 1'b0, 4'd15, 4'd0);
        for (int i = 0; i < 3; i++) step("pop3", 1'b0, 1'b1, 4'd0, 4'd0);
        step("idle1", 1'b0, 1'b0, 4'd0, 4'd0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 4'(i), 4'(15 - i));
        step("overflow", 1'b1, 1'b0, 4'd5, 4'd5);
        step("idle2",    1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 4'd0, 4'd0);

        // Full queue with simultaneous push/pop, continuing past both wraps
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, 4'(i), 4'(15 - i));
        step("full_pp", 1'b1, 1'b1, 4'd9, 4'd9);
        for (int i = 0; i < 20; i++) step("wrap_pp", 1'b1, 1'b1, 4'(i + 3), 4'(i * 7));
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 4'd0, 4'd0);

        // Push and pop together on an empty queue: push lands, pop fails
        step("empty_pp", 1'b1, 1'b1, 4'd4, 4'd4);
        step("pop44",    1'b0, 1'b1, 4'd0, 4'd0);
        step("mid_pp_a", 1'b1, 1'b0, 4'd1, 4'd2);
        step("mid_pp_b", 1'b1, 1'b1, 4'd6, 4'd8);
        step("mid_pp_c", 1'b0, 1'b1, 4'd0, 4'd0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 4'(i + 10), 4'(i));
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        #2;
        rst = 1'b1;
        sb.delete();
        exp_out = '0;
        #1;
        check_all("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        push = 1'b1; pop = 1'b1; xIn = 4'd7; yIn = 4'd7;
        @(posedge clk);
        #1;
        check_all("rst_held", 1'b0, 1'b0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        rst = 1'b0;
        step("post_rst_pop", 1'b0, 1'b1, 4'd0, 4'd0);
        step("idle3",        1'b0, 1'b0, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_coord_queue
`default_nettype wire
